// File: rtl/packet_filter_pkg.sv
// Shared definitions for the frame generator / frame monitor pair:
// parser states, header geometry and the common 8-bit register map.
package packet_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DRAIN
  } mon_state_t;

  localparam int unsigned HDR_BEATS = 8;

  localparam logic [7:0] REG_DST    = 8'd0;
  localparam logic [7:0] REG_SRC    = 8'd6;
  localparam logic [7:0] REG_LEN    = 8'd12;
  localparam logic [7:0] REG_TYPE   = 8'd14;
  localparam logic [7:0] REG_CSUM   = 8'd16;
  localparam logic [7:0] REG_GOOD   = 8'd20;
  localparam logic [7:0] REG_ERR    = 8'd22;
  localparam logic [7:0] REG_STATUS = 8'd23;
  localparam logic [7:0] REG_CLEAR  = 8'd24;
  localparam logic [7:0] REG_STALL  = 8'd25;

  // Byte 0 of a MAC is the earliest wire byte, held in the top bits.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac >> {3'd5 - idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/frame_monitor_csr.sv
// Visible register file, good/error counters, clear and Avalon readback.
// FRAME_MONITOR_STALL_EN adds the stall-pattern register at address 25.
module frame_monitor_csr
  import packet_filter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  input  logic        commit_good,
  input  logic        commit_err,
  input  logic        in_frame,
  input  logic [47:0] dst,
  input  logic [47:0] src,
  input  logic [15:0] len,
  input  logic [15:0] ftype,
  input  logic [31:0] csum
`ifdef FRAME_MONITOR_STALL_EN
  ,
  output logic        stall_load
`endif
);

  logic [47:0] vis_dst, vis_src;
  logic [15:0] vis_len, vis_type, good_cnt;
  logic [31:0] vis_csum;
  logic [7:0]  err_cnt, rd_mux;
  logic        last_err, clear;

  assign clear = chipselect && write && (address == REG_CLEAR);

`ifdef FRAME_MONITOR_STALL_EN
  logic [7:0] stall_pattern;
  assign stall_load = chipselect && write && (address == REG_STALL);

  always_ff @(posedge clk) begin
    if (reset)           stall_pattern <= '0;
    else if (stall_load) stall_pattern <= writedata;
  end
`else
  logic unused_writedata;
  assign unused_writedata = ^writedata;
`endif

  // Clear beats a coincident commit for counters/status, but not for the fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      vis_dst  <= '0;
      vis_src  <= '0;
      vis_len  <= '0;
      vis_type <= '0;
      vis_csum <= '0;
      good_cnt <= '0;
      err_cnt  <= '0;
      last_err <= 1'b0;
    end else begin
      if (commit_good) begin
        vis_dst  <= dst;
        vis_src  <= src;
        vis_len  <= len;
        vis_type <= ftype;
        vis_csum <= csum;
      end
      if (clear) begin
        good_cnt <= '0;
        err_cnt  <= '0;
        last_err <= 1'b0;
      end else begin
        if (commit_good) begin
          good_cnt <= good_cnt + 16'd1;
          last_err <= 1'b0;
        end
        if (commit_err) begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          last_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5:       rd_mux = mac_byte(vis_dst, address[2:0]);
      8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11:     rd_mux = mac_byte(vis_src, 3'(address - REG_SRC));
      REG_LEN:           rd_mux = vis_len[7:0];
      REG_LEN + 8'd1:    rd_mux = vis_len[15:8];
      REG_TYPE:          rd_mux = vis_type[15:8];
      REG_TYPE + 8'd1:   rd_mux = vis_type[7:0];
      REG_CSUM:          rd_mux = vis_csum[7:0];
      REG_CSUM + 8'd1:   rd_mux = vis_csum[15:8];
      REG_CSUM + 8'd2:   rd_mux = vis_csum[23:16];
      REG_CSUM + 8'd3:   rd_mux = vis_csum[31:24];
      REG_GOOD:          rd_mux = good_cnt[7:0];
      REG_GOOD + 8'd1:   rd_mux = good_cnt[15:8];
      REG_ERR:           rd_mux = err_cnt;
      REG_STATUS:        rd_mux = {6'd0, last_err, in_frame};
`ifdef FRAME_MONITOR_STALL_EN
      REG_STALL:         rd_mux = stall_pattern;
`endif
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= (chipselect && read) ? rd_mux : '0;
  end

endmodule

// File: rtl/frame_monitor.sv
// Ingress frame parser: header capture, length/tlast check, payload checksum.
// Optional FRAME_MONITOR_STALL_EN adds a rotating tready stall pattern.
module frame_monitor
  import packet_filter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  input  logic [15:0] ingress_port_tdata,
  input  logic        ingress_port_tlast,
  input  logic        ingress_port_tvalid,
  output logic        ingress_port_tready
);

  mon_state_t  state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [47:0] dst_w, src_w, dst_n, src_n;
  logic [15:0] len_w, len_n, type_w, type_n, pay_beats;
  logic [31:0] csum_w, csum_n;
  logic        xfer, hdr_last, last_pay, commit_good, commit_err;

  assign xfer      = ingress_port_tvalid && ingress_port_tready;
  assign pay_beats = {1'b0, len_w[15:1]} + {15'd0, len_w[0]};
  assign hdr_last  = (cnt == 16'(HDR_BEATS - 1));
  assign last_pay  = (cnt == pay_beats - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (xfer) begin
      case (state)
        IDLE:    state_next = ingress_port_tlast ? IDLE : HEADER;
        HEADER:  if (ingress_port_tlast) state_next = IDLE;
                 else if (hdr_last)      state_next = (len_w != '0) ? PAYLOAD : DRAIN;
        PAYLOAD: if (ingress_port_tlast) state_next = IDLE;
                 else if (last_pay)      state_next = DRAIN;
        DRAIN:   if (ingress_port_tlast) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Length errors are committed when detected; DRAIN only discards.
  always_comb begin
    commit_good = 1'b0;
    commit_err  = 1'b0;
    if (xfer) begin
      case (state)
        IDLE:    commit_err = ingress_port_tlast;
        HEADER: begin
          if (ingress_port_tlast) begin
            commit_good = hdr_last && (len_w == '0);
            commit_err  = !(hdr_last && (len_w == '0));
          end else begin
            commit_err  = hdr_last && (len_w == '0);
          end
        end
        PAYLOAD: begin
          commit_good = ingress_port_tlast && last_pay;
          commit_err  = ingress_port_tlast != last_pay;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_next = cnt;
    dst_n    = dst_w;
    src_n    = src_w;
    len_n    = len_w;
    type_n   = type_w;
    csum_n   = csum_w;
    if (xfer) begin
      case (state)
        IDLE: begin
          dst_n    = {ingress_port_tdata, dst_w[31:0]};
          csum_n   = '0;
          cnt_next = 16'd1;
        end
        HEADER: begin
          cnt_next = hdr_last ? 16'd0 : cnt + 16'd1;
          case (cnt[2:0])
            3'd1: dst_n[31:16] = ingress_port_tdata;
            3'd2: dst_n[15:0]  = ingress_port_tdata;
            3'd3: src_n[47:32] = ingress_port_tdata;
            3'd4: src_n[31:16] = ingress_port_tdata;
            3'd5: src_n[15:0]  = ingress_port_tdata;
            3'd6: len_n        = {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
            3'd7: type_n       = ingress_port_tdata;
            default: ;
          endcase
        end
        PAYLOAD: begin
          cnt_next = cnt + 16'd1;
          csum_n   = csum_w + {24'd0, ingress_port_tdata[15:8]}
                   + ((last_pay && len_w[0]) ? 32'd0 : {24'd0, ingress_port_tdata[7:0]});
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      dst_w  <= '0;
      src_w  <= '0;
      len_w  <= '0;
      type_w <= '0;
      csum_w <= '0;
    end else begin
      cnt    <= cnt_next;
      dst_w  <= dst_n;
      src_w  <= src_n;
      len_w  <= len_n;
      type_w <= type_n;
      csum_w <= csum_n;
    end
  end

`ifdef FRAME_MONITOR_STALL_EN
  logic       stall_load;
  logic [7:0] rot;

  // tready always reflects ~rot[0]; a pattern write restarts the rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      rot                 <= '0;
      ingress_port_tready <= 1'b0;
    end else if (stall_load) begin
      rot                 <= writedata;
      ingress_port_tready <= !writedata[0];
    end else begin
      rot                 <= {rot[0], rot[7:1]};
      ingress_port_tready <= !rot[1];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) ingress_port_tready <= 1'b0;
    else       ingress_port_tready <= 1'b1;
  end
`endif

  frame_monitor_csr u_csr (
    .clk         (clk),
    .reset       (reset),
    .writedata   (writedata),
    .write       (write),
    .chipselect  (chipselect),
    .address     (address),
    .read        (read),
    .readdata    (readdata),
    .commit_good (commit_good),
    .commit_err  (commit_err),
    .in_frame    (state != IDLE),
    .dst         (dst_n),
    .src         (src_n),
    .len         (len_n),
    .ftype       (type_n),
    .csum        (csum_n)
`ifdef FRAME_MONITOR_STALL_EN
    ,
    .stall_load  (stall_load)
`endif
  );

endmodule
